// File: rtl/fact_seq_ctrl_if.sv
// Request/response bundle between a requester and the factorial sequencer.
// The master raises go with an operand n; the slave reports busy, a one-cycle
// done pulse, and the held result with its overflow flag.
interface fact_seq_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 32
);
  logic              go;
  logic [DATA_W-1:0] n;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  result;
  logic              err;

  modport master (
    output go,
    output n,
    input  busy,
    input  done,
    input  result,
    input  err
  );

  modport slave (
    input  go,
    input  n,
    output busy,
    output done,
    output result,
    output err
  );
endinterface

// File: rtl/fact_seq_ctrl.sv
// Factorial sequencing engine: loadable down-counter plus product register,
// stepped by an IDLE/RUN/DONE state machine. result is n! truncated to RES_W.
// Optional macro FACT_OVF_CHECK_EN: multiplies are formed at 2*RES_W bits and
// any nonzero upper half sets a sticky overflow reported on err; without it
// err is constant 0 and no wide multiplier exists.
module fact_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  fact_seq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [DATA_W-1:0] cnt_r;
  logic [RES_W-1:0]  prod_r;
  logic [RES_W-1:0]  result_r;
  logic              done_r;
  logic              cnt_le1_s;
  logic [RES_W-1:0]  cnt_ext_s;
  logic [RES_W-1:0]  prod_nxt_s;

  assign cnt_le1_s = (cnt_r <= DATA_W'(1));
  assign cnt_ext_s = RES_W'(cnt_r);

`ifdef FACT_OVF_CHECK_EN
  logic [2*RES_W-1:0] wide_s;
  logic               step_ovf_s;
  logic               ovf_r;
  logic               err_r;

  assign wide_s     = {{RES_W{1'b0}}, prod_r} * {{RES_W{1'b0}}, cnt_ext_s};
  assign prod_nxt_s = wide_s[RES_W-1:0];
  assign step_ovf_s = |wide_s[2*RES_W-1:RES_W];
  assign bus.err    = err_r;
`else
  assign prod_nxt_s = prod_r * cnt_ext_s;
  assign bus.err    = 1'b0;
`endif

  assign bus.busy   = (state_r != ST_IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; go is only looked at while idle, so it is never queued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.go) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_le1_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Counter, product and published result; done is registered so it is high
  // exactly while the machine sits in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {DATA_W{1'b0}};
      prod_r   <= {RES_W{1'b0}};
      result_r <= {RES_W{1'b0}};
      done_r   <= 1'b0;
`ifdef FACT_OVF_CHECK_EN
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
`endif
    end else begin
      done_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.go) begin
            cnt_r  <= bus.n;
            prod_r <= RES_W'(1);
`ifdef FACT_OVF_CHECK_EN
            ovf_r  <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (cnt_le1_s) begin
            result_r <= prod_r;
`ifdef FACT_OVF_CHECK_EN
            err_r    <= ovf_r;
`endif
          end else begin
            prod_r <= prod_nxt_s;
            cnt_r  <= cnt_r - DATA_W'(1);
`ifdef FACT_OVF_CHECK_EN
            ovf_r  <= ovf_r | step_ovf_s;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Randomized scoreboard bench for fact_seq_ctrl: a driver issues requests and
// queues the expected result/err/done-cycle from a plain-arithmetic factorial
// model; a negedge monitor pops and compares on every done pulse.
module tb_fact_seq_ctrl;

  localparam int DATA_W = 4;
  localparam int RES_W  = 32;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          tests;
  int          fails;
  exp_t        sb_q[$];

  fact_seq_ctrl_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  fact_seq_ctrl #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: true n! in 64 bits (n <= 15 fits), then reduce to RES_W.
  function automatic exp_t model(input int nv, input int unsigned acc);
    exp_t e;
    longint unsigned f;
    f = 1;
    for (int i = 2; i <= nv; i++) f = f * longint'(i);
    e.res = f[31:0];
`ifdef FACT_OVF_CHECK_EN
    e.err = (f >= 64'h1_0000_0000);
`else
    e.err = 1'b0;
`endif
    e.cyc = acc + ((nv < 2) ? 1 : nv);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got result %0d with no request outstanding", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("err", 64'(bus.err), 64'(e.err));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (bus.busy && t < 100);
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", bus.busy, t);
    end
  endtask

  task automatic start_op(input int nv, input bit push);
    int unsigned acc;
    wait_idle();
    bus.go = 1'b1;
    bus.n  = DATA_W'(nv);
    acc    = cyc + 1;
    if (push) sb_q.push_back(model(nv, acc));
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    bus.n  = DATA_W'($urandom);
    check("busy_after_go", 64'(bus.busy), 64'd1);
  endtask

  initial begin
    int unsigned acc;
    int          dir_n[6];
    int          t;
    tests  = 0;
    fails  = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.go = 1'b0;
    bus.n  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;

    // Directed operands: typical, both short cases, last fit, first overflow, max.
    dir_n = '{5, 0, 1, 12, 13, 15};
    foreach (dir_n[i]) start_op(dir_n[i], 1'b1);

    // go held high through RUN and DONE: one run of 6, then a second run of 3.
    wait_idle();
    bus.go = 1'b1;
    bus.n  = DATA_W'(6);
    acc    = cyc + 1;
    sb_q.push_back(model(6, acc));
    sb_q.push_back(model(3, acc + 8));
    @(posedge clk);
    #1;
    bus.n = DATA_W'(3);
    while (cyc < acc + 8) begin
      @(posedge clk);
      #1;
    end
    bus.go = 1'b0;

    // Asynchronous reset between edges aborts a run of 7 with nothing published.
    start_op(7, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_err", 64'(bus.err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    start_op(4, 1'b1);

    // Result is held and done stays low across a long idle stretch.
    start_op(3, 1'b1);
    wait_idle();
    repeat (10) begin
      @(posedge clk);
      #1;
      check("hold_result", 64'(bus.result), 64'd6);
      check("hold_done", 64'(bus.done), 64'd0);
      check("hold_busy", 64'(bus.busy), 64'd0);
    end

    // Random operands with random idle gaps.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_op(int'($urandom_range(0, 15)), 1'b1);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
- Sequencing engine for factorial computation, with a start/done handshake.
- Contains its own loadable down-counter and product register. Its FSM drives the counter's load and enable.
- Sits between the top-level request interface and the datapath. Accepts an operand `n` and returns `n!` after a deterministic number of cycles.

Parameters:
- DATA_W, 4, width of operand `n` and of the internal down-counter.
- RES_W, 32, width of the product register and of `result`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high. Clears all state immediately.
- go  input  1  start request; sampled only in IDLE.
- n  input  DATA_W  operand; captured on the edge where `go` is accepted.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse; `result` and `err` are valid from this cycle on.
- result  output  RES_W  registered `n!` (truncated to RES_W bits). Held until the next `done`.
- err  output  1  overflow flag for the current `result`. Held alongside `result`.

Behaviour:
- Reset values: state=IDLE, cnt=0, prod=0, result=0, err=0, done=0, busy=0.
  - Asserting `rst` mid-computation aborts it immediately.
  - No partial result is published.
- States: IDLE, RUN, DONE.
- IDLE:
  - If `go`=1: cnt<=n, prod<=1, ovf<=0, next state RUN.
  - Otherwise hold.
- RUN, when cnt<=1:
  - result<=prod, err<=ovf, next state DONE.
  - cnt and prod hold.
- RUN, when cnt>1:
  - prod<=prod*cnt (cnt zero-extended to RES_W).
  - cnt<=cnt-1.
  - Stay in RUN.
- DONE:
  - done=1 for exactly this cycle, then unconditionally return to IDLE.
- `go` outside IDLE (RUN or DONE) is ignored and never queued. Back-to-back operation therefore needs `go` asserted in the cycle after `done`.
- Latency: `go` accepted at edge E → `done` high in the cycle after edge E+max(n,1).
  - n=0 and n=1 both take 1 RUN cycle and yield result=1.
- `busy` is combinational from state: 1 in RUN and DONE.
- Width rule: the product is truncated to RES_W bits at every step, i.e. the result is `n!` mod 2^RES_W.
- `n` is don't-care except on the accepting edge.
- `result`/`err` change only on entry to DONE.

Optional Feature:
- Macro: FACT_OVF_CHECK_EN.
- Defined:
  - Each multiply is computed at 2*RES_W bits.
  - If any upper RES_W bits are nonzero, the internal ovf flag is set and stays sticky for the rest of the operation.
  - `err` reports it with the result.
  - Truncated arithmetic continues.
- Not defined:
  - No wide multiply or ovf logic is generated.
  - `err` is tied to 0.
  - `result` is still `n!` mod 2^RES_W.

Test Plan:
- n=5, `go` pulse at edge E → busy=1 from E; `done` pulse after E+5; result=120, err=0; busy=0 the cycle after `done`.
- n=0, then separately n=1 → `done` after E+1 each time, result=1, err=0.
- n=12 (RES_W=32) → result=479001600, err=0. n=13 → result=1932053504; err=1 with FACT_OVF_CHECK_EN, err=0 without.
- n=6 started, then `go` held high with n=3 throughout RUN and DONE → exactly one `done` with result=720. With `go` still high in the following IDLE cycle, a second run starts and ends with result=6.
- n=7 started, `rst` asserted asynchronously mid-RUN (between edges) → busy, done, result and err go to 0 immediately. No `done` appears afterwards. A fresh n=4 run after reset release returns 24.
- n=3 completes (result=6); then hold go=0 for 10 cycles → result stays 6, done stays 0, busy stays 0.
